regfile_nr1w: RTL
=================

# regfile_nr1w

Parametrised multi-read, single-write register file with registered read ports, same-cycle write-to-read bypass and a per-register pending scoreboard. It generalises the two-lane 2R1W register file to `NUM_READ` read ports over one shared storage array. It sits between decode/issue (reads, reservations) and writeback (writes) in the core datapath.

## Interface

- `NUM_READ`, 2, number of read ports (1..4)
- `DEPTH_LOG2`, 5, address width; depth = 2**DEPTH_LOG2
- `WIDTH`, 32, data width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `rs_read` in NUM_READ: per-port read enable
- `rs_addr` in NUM_READ*DEPTH_LOG2: packed read addresses, port i at [i*DEPTH_LOG2 +: DEPTH_LOG2]
- `rs_rdata` out NUM_READ*WIDTH: packed registered read data
- `rs_ready` out NUM_READ: registered flag, 1 = returned register was not pending
- `rd_write` in 1: write enable
- `rd_addr` in DEPTH_LOG2: write address
- `rd_wdata` in WIDTH: write data
- `rsv_valid` in 1: reserve (mark pending) request
- `rsv_addr` in DEPTH_LOG2: register to reserve
- `pending` out 2**DEPTH_LOG2: current scoreboard, bit n = register n pending

## Operation

- Storage: 2**DEPTH_LOG2 x WIDTH flops. Pending: one bit per register.
- Write: when `rd_write` is 1 at an edge, `mem[rd_addr]` <= `rd_wdata` and `pending[rd_addr]` <= 0.
- Reserve: when `rsv_valid` is 1 at an edge, `pending[rsv_addr]` <= 1.
- Reserve and write to the same address in the same cycle: data is written and pending ends at 1. The reserve wins.
- Read port i: when `rs_read[i]` is 1 at an edge:
  - `rs_rdata[i]` loads `mem[rs_addr[i]]`.
  - Bypass: if `rd_write` is 1 and `rd_addr == rs_addr[i]`, it loads `rd_wdata` instead.
  - `rs_ready[i]` loads the inverse of the pending bit after this cycle's write clear and before this cycle's reserve.
- When `rs_read[i]` is 0, `rs_rdata[i]` and `rs_ready[i]` hold their values.
- Multiple ports may read the same address in one cycle; each port behaves independently.
- No arithmetic. Addresses index the full range with no wrap.

## Timing

- Read latency is 1 cycle: data is visible after the edge that sampled `rs_read`.
- Write is visible to a storage read on the next cycle, and to a same-cycle read through the bypass.
- `pending` updates on the edge after `rd_write` or `rsv_valid`.
- Reset (asynchronous, any time, including mid-operation):
  - all storage = 0
  - `pending` = 0
  - `rs_rdata` = 0
  - `rs_ready` = all 1
- After reset deasserts, the first edge behaves normally. No request is lost or replayed across reset; in-flight requests are dropped.

## Configuration

- `REGFILE_ZERO_REG_EN` defined:
  - register 0 is hardwired to zero
  - writes to address 0 are ignored, including the bypass, so reads of address 0 return 0
  - reserves to address 0 are ignored
  - `pending[0]` is constantly 0 and reads of address 0 give `rs_ready` = 1
- Undefined: register 0 is an ordinary register.

## Structure

- Package `regfile_pkg`: default parameter constants (`RF_DEPTH_LOG2`, `RF_WIDTH`, `RF_NUM_READ`) and typedefs `rf_addr_t` and `rf_data_t`.
- Sub-module `regfile_read_port`, instantiated `NUM_READ` times in a generate loop:
  - inputs: storage array slice, pending vector, write bypass signals
  - owns the `rs_rdata`/`rs_ready` registers for one port
- The top level owns storage, the scoreboard and the reset.

## Test plan

- Reset, then read all ports at addr 0..3 -> `rs_rdata` = 0, `rs_ready` = 1, `pending` = 0.
- Write 0xDEADBEEF to r5, next cycle read r5 on ports 0 and 1 -> both return 0xDEADBEEF, ready = 1.
- Bypass: same cycle write 0x12345678 to r7 and read r7 on port 1 -> port 1 returns 0x12345678; a concurrent port 0 read of r6 returns the old r6.
- Scoreboard:
  - reserve r9, then read r9 -> `rs_ready` = 0 and `pending[9]` = 1
  - write r9 = 0xA5A5A5A5 -> `pending[9]` = 0 next cycle, and a same-cycle read shows ready = 1 with the bypassed data
- Simultaneous reserve and write on r3 -> r3 holds the new data and `pending[3]` = 1. With `REGFILE_ZERO_REG_EN`: write 0xFFFFFFFF to r0 and reserve r0 -> reads return 0, ready = 1.
- Assert `rst_n` low mid-stream with r4 pending and port 0 holding 0xCAFEF00D -> outputs are immediately 0 / ready 1 / `pending` = 0 without a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-read, single-write register file.
package regfile_pkg;

    localparam int unsigned RF_DEPTH_LOG2 = 5;
    localparam int unsigned RF_WIDTH      = 32;
    localparam int unsigned RF_NUM_READ   = 2;

    typedef logic [RF_DEPTH_LOG2-1:0] rf_addr_t;
    typedef logic [RF_WIDTH-1:0]      rf_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: storage lookup with same-cycle write bypass and a
// ready flag taken from the scoreboard after this cycle's write clear.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = RF_DEPTH_LOG2,
    parameter int unsigned WIDTH      = RF_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   rs_read,
    input  logic [DEPTH_LOG2-1:0]                  rs_addr,
    input  logic [2**DEPTH_LOG2-1:0][WIDTH-1:0]    mem,
    input  logic [2**DEPTH_LOG2-1:0]               pending,
    input  logic                                   wr_en,
    input  logic [DEPTH_LOG2-1:0]                  wr_addr,
    input  logic [WIDTH-1:0]                       wr_data,
    output logic [WIDTH-1:0]                       rs_rdata,
    output logic                                   rs_ready
);

    logic             hit;
    logic [WIDTH-1:0] next_data;
    logic             next_ready;

    // A write to the same address both supplies the data and clears pending,
    // so a bypassed read always reports ready.
    always_comb begin
        hit        = wr_en && (wr_addr == rs_addr);
        next_data  = hit ? wr_data : mem[rs_addr];
        next_ready = hit || !pending[rs_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_rdata <= '0;
            rs_ready <= 1'b1;
        end else if (rs_read) begin
            rs_rdata <= next_data;
            rs_ready <= next_ready;
        end
    end

endmodule

// File: rtl/regfile_nr1w.sv
// NUM_READ-read, 1-write register file with bypass and pending scoreboard.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero and never pending.
module regfile_nr1w
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_READ   = RF_NUM_READ,
    parameter int unsigned DEPTH_LOG2 = RF_DEPTH_LOG2,
    parameter int unsigned WIDTH      = RF_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ-1:0]            rs_read,
    input  logic [NUM_READ*DEPTH_LOG2-1:0] rs_addr,
    output logic [NUM_READ*WIDTH-1:0]      rs_rdata,
    output logic [NUM_READ-1:0]            rs_ready,
    input  logic                           rd_write,
    input  logic [DEPTH_LOG2-1:0]          rd_addr,
    input  logic [WIDTH-1:0]               rd_wdata,
    input  logic                           rsv_valid,
    input  logic [DEPTH_LOG2-1:0]          rsv_addr,
    output logic [2**DEPTH_LOG2-1:0]       pending
);

    localparam int unsigned DEPTH = 2**DEPTH_LOG2;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [DEPTH-1:0]            pend;
    logic                        wr_en;
    logic                        rsv_en;

`ifdef REGFILE_ZERO_REG_EN
    // Address 0 requests are dropped here so storage, scoreboard and bypass
    // all see register 0 as constant zero.
    assign wr_en  = rd_write  && (rd_addr  != '0);
    assign rsv_en = rsv_valid && (rsv_addr != '0);
`else
    assign wr_en  = rd_write;
    assign rsv_en = rsv_valid;
`endif

    // Reserve is applied after the write clear so it wins on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem  <= '0;
            pend <= '0;
        end else begin
            if (wr_en) begin
                mem[rd_addr]  <= rd_wdata;
                pend[rd_addr] <= 1'b0;
            end
            if (rsv_en) begin
                pend[rsv_addr] <= 1'b1;
            end
        end
    end

    assign pending = pend;

    for (genvar i = 0; i < NUM_READ; i++) begin : g_port
        regfile_read_port #(
            .DEPTH_LOG2 (DEPTH_LOG2),
            .WIDTH      (WIDTH)
        ) u_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .rs_read  (rs_read[i]),
            .rs_addr  (rs_addr[i*DEPTH_LOG2 +: DEPTH_LOG2]),
            .mem      (mem),
            .pending  (pend),
            .wr_en    (wr_en),
            .wr_addr  (rd_addr),
            .wr_data  (rd_wdata),
            .rs_rdata (rs_rdata[i*WIDTH +: WIDTH]),
            .rs_ready (rs_ready[i])
        );
    end

endmodule
